// File: rtl/seq_nibble_adder.sv
// Multi-cycle WIDTH-bit adder that streams operand nibbles through one 4-bit CLA slice.
// Optional subtract support is compiled in with `define SEQ_NIBBLE_SUB_EN.

module cla_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       p,
  output logic       g
);

  logic [3:0] gen_s;
  logic [3:0] prop_s;
  logic [3:0] c_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Flattened look-ahead carries; no carry ripples between bit positions.
  assign c_s[0] = c_in;
  assign c_s[1] = gen_s[0] | (prop_s[0] & c_in);
  assign c_s[2] = gen_s[1] | (prop_s[1] & gen_s[0]) | (prop_s[1] & prop_s[0] & c_in);
  assign c_s[3] = gen_s[2] | (prop_s[2] & gen_s[1]) | (prop_s[2] & prop_s[1] & gen_s[0])
                | (prop_s[2] & prop_s[1] & prop_s[0] & c_in);

  assign p     = &prop_s;
  assign g     = gen_s[3] | (prop_s[3] & gen_s[2]) | (prop_s[3] & prop_s[2] & gen_s[1])
               | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]);
  assign c_out = g | (p & c_in);
  assign s     = prop_s ^ c_s;

endmodule

module seq_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SEQ_NIBBLE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;
  logic [3:0]       nib_sum_s;
  logic             nib_cout_s;
  logic [WIDTH+3:0] acc_cat_s;
  logic             c_msb_s;

`ifdef SEQ_NIBBLE_SUB_EN
  assign b_eff_s   = sub ? ~b : b;
  assign cin_eff_s = sub ? 1'b1 : c_in;
`else
  assign b_eff_s   = b;
  assign cin_eff_s = c_in;
`endif

  cla_4_bit u_slice (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .c_in  (carry_q),
    .s     (nib_sum_s),
    .c_out (nib_cout_s),
    .p     (),
    .g     ()
  );

  // New nibble enters at the top so the last nibble lands in the MSBs.
  assign acc_cat_s = {nib_sum_s, acc_q};
  // On the final RUN cycle the low operand bits are the original MSBs.
  assign c_msb_s   = a_q[3] ^ b_q[3] ^ nib_sum_s[3];

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b_eff_s;
          carry_d    = cin_eff_s;
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_cat_s[WIDTH+3:4];
        carry_d = nib_cout_s;
        a_d     = a_q >> 3'd4;
        b_d     = b_q >> 3'd4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d       = acc_cat_s[WIDTH+3:4];
          c_out_d     = nib_cout_s;
          ovf_d       = c_msb_s ^ nib_cout_s;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_nibble_adder.sv
// Scoreboard bench for seq_nibble_adder: WIDTH=16 random/directed traffic plus a WIDTH=4 directed case.

module tb_seq_nibble_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, c_in, sub_s;
  logic [W-1:0] a, b, sum;
  logic         out_valid, out_ready, c_out, overflow;

  logic         in_valid4, in_ready4, c_in4, sub4, out_valid4, c_out4, ovf4;
  logic [3:0]   a4, b4, sum4;
  logic         out_ready4 = 1'b1;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_nibble_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef SEQ_NIBBLE_SUB_EN
    .sub(sub_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  seq_nibble_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c_in(c_in4),
`ifdef SEQ_NIBBLE_SUB_EN
    .sub(sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .c_out(c_out4), .overflow(ovf4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; overflow means the signed result leaves the W-bit range.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic sb);
    exp_t         e;
    logic [W-1:0] bp;
    logic         cie;
    logic [W:0]   full;
    longint       r;
    bp   = sb ? ~bv : bv;
    cie  = sb ? 1'b1 : ci;
    full = (W+1)'(av) + (W+1)'(bp) + (W+1)'(cie);
    r    = longint'($signed(av)) + longint'($signed(bp)) + longint'(cie);
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (r > ((64'sd1 <<< (W-1)) - 1)) || (r < -(64'sd1 <<< (W-1)));
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every cycle a result is presented it must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ready && out_valid) chk("ready_valid_exclusive", 32'd1, 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("sum", 32'(sum), 32'(exp_q[0].s));
          chk("c_out", 32'(c_out), 32'(exp_q[0].c));
          chk("overflow", 32'(overflow), 32'(exp_q[0].v));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci, input logic sb);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; c_in = ci; sub_s = sb; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout", 32'd0, 32'd1);
`ifdef SEQ_NIBBLE_SUB_EN
    exp_q.push_back(model(av, bv, ci, sb));
`else
    exp_q.push_back(model(av, bv, ci, 1'b0));
`endif
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub_s = 1'b0;
    in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; c_in4 = 1'b0; sub4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    chk("latency_w16", 32'(lat), 32'd4);
    drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
`ifdef SEQ_NIBBLE_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
`endif
    drain();

    // Back-pressure: result frozen in DONE, new operands refused.
    rdy_mode = 1;
    @(posedge clk);
    send(16'hABCD, 16'h6789, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset two cycles into RUN discards the operation.
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_c_out", 32'(c_out), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h2468, 16'h1357, 1'b1, 1'b0);
    drain();

    // Randomized traffic with random consumer back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    rdy_mode = 0;

    // WIDTH=4: 9 + 8 + 1 = 0x12, signed -7 + -8 + 1 = -14 overflows.
    @(negedge clk);
    chk("w4_in_ready", 32'(in_ready4), 32'd1);
    a4 = 4'h9; b4 = 4'h8; c_in4 = 1'b1; sub4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    @(negedge clk);
    chk("w4_not_yet_valid", 32'(out_valid4), 32'd0);
    @(negedge clk);
    chk("w4_out_valid", 32'(out_valid4), 32'd1);
    chk("w4_sum", 32'(sum4), 32'h2);
    chk("w4_c_out", 32'(c_out4), 32'd1);
    chk("w4_overflow", 32'(ovf4), 32'd1);
    @(negedge clk);
    chk("w4_back_idle", 32'(in_ready4), 32'd1);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
